ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32I core; sits directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus the ID/EX operands, and computes the ALU result, branch outcome and jump target.
- Holds the EX/MEM pipeline register with valid/ready handshakes, and issues a registered redirect to the fetch stage.

---
 rtl/ex_stage_if.sv | 52 +++++
 rtl/ex_stage.sv | 170 +++++++++++++++++
 tb/tb_ex_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle plus the fetch redirect.
// The master side is the upstream/downstream environment, the slave side is ex_stage itself.
interface ex_stage_if #(
   parameter int XLEN = 32
);
   // ID/EX side
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_ctrl;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] pc;
   logic            b_sel;
   logic            is_jal;
   logic            is_jalr;
   logic [4:0]      rd_addr;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic [2:0]      funct3;
   logic            flush;

   // EX/MEM side
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [XLEN-1:0] out_store_data;
   logic [4:0]      out_rd;
   logic            out_reg_write;
   logic            out_mem_read;
   logic            out_mem_write;
   logic [2:0]      out_funct3;

   // Fetch redirect
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_target;

   modport master (
      output in_valid, alu_ctrl, rs1_data, rs2_data, imm, pc, b_sel, is_jal, is_jalr,
             rd_addr, reg_write, mem_read, mem_write, funct3, flush, out_ready,
      input  in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
             out_mem_read, out_mem_write, out_funct3, redirect_valid, redirect_target
   );

   modport slave (
      input  in_valid, alu_ctrl, rs1_data, rs2_data, imm, pc, b_sel, is_jal, is_jalr,
             rd_addr, reg_write, mem_read, mem_write, funct3, flush, out_ready,
      output in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
             out_mem_read, out_mem_write, out_funct3, redirect_valid, redirect_target
   );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: ALU, branch resolution, jump target generation,
// EX/MEM pipeline register with valid/ready, and a registered fetch redirect.
module ex_stage #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC_TGT = '0
) (
   input  logic       clk,
   input  logic       rst_n,
   ex_stage_if.slave  bus
);

   // ALU codes
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLL  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_BEQ  = 4'b1010;
   localparam logic [3:0] OP_BNE  = 4'b1011;
   localparam logic [3:0] OP_BLT  = 4'b1100;
   localparam logic [3:0] OP_BGE  = 4'b1101;
   localparam logic [3:0] OP_BLTU = 4'b1110;
   localparam logic [3:0] OP_BGEU = 4'b1111;

   // Combinational datapath
   logic [XLEN-1:0] w_b;
   logic [4:0]      w_shamt;
   logic            w_slt;
   logic            w_sltu;
   logic            w_br_eq;
   logic            w_br_lt;
   logic            w_br_ltu;
   logic [XLEN-1:0] w_alu;
   logic            w_br_taken;
   logic            w_jump;
   logic            w_taken;
   logic [XLEN-1:0] w_pc4;
   logic [XLEN-1:0] w_jalr_sum;
   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_result;
   logic            w_in_ready;
   logic            w_accept;

   // EX/MEM register
   logic            r_out_valid;
   logic [XLEN-1:0] r_out_result;
   logic [XLEN-1:0] r_out_store_data;
   logic [4:0]      r_out_rd;
   logic            r_out_reg_write;
   logic            r_out_mem_read;
   logic            r_out_mem_write;
   logic [2:0]      r_out_funct3;

   // Redirect register
   logic            r_redirect_valid;
   logic [XLEN-1:0] r_redirect_target;

   // Operand B selects the immediate for I-type ops; branches always
   // compare the two registers, so they use rs2_data directly below.
   assign w_b     = bus.b_sel ? bus.imm : bus.rs2_data;
   assign w_shamt = w_b[4:0];

   assign w_slt    = $signed(bus.rs1_data) < $signed(w_b);
   assign w_sltu   = bus.rs1_data < w_b;
   assign w_br_eq  = bus.rs1_data == bus.rs2_data;
   assign w_br_lt  = $signed(bus.rs1_data) < $signed(bus.rs2_data);
   assign w_br_ltu = bus.rs1_data < bus.rs2_data;

   // ALU result; branch codes fall through to zero
   always_comb begin
      w_alu = '0;
      case (bus.alu_ctrl)
         OP_ADD:  w_alu = bus.rs1_data + w_b;
         OP_SUB:  w_alu = bus.rs1_data - w_b;
         OP_SLL:  w_alu = bus.rs1_data << w_shamt;
         OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, w_slt};
         OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, w_sltu};
         OP_XOR:  w_alu = bus.rs1_data ^ w_b;
         OP_SRL:  w_alu = bus.rs1_data >> w_shamt;
         OP_SRA:  w_alu = $unsigned($signed(bus.rs1_data) >>> w_shamt);
         OP_OR:   w_alu = bus.rs1_data | w_b;
         OP_AND:  w_alu = bus.rs1_data & w_b;
         default: w_alu = '0;
      endcase
   end

   // Branch condition evaluation
   always_comb begin
      w_br_taken = 1'b0;
      case (bus.alu_ctrl)
         OP_BEQ:  w_br_taken = w_br_eq;
         OP_BNE:  w_br_taken = !w_br_eq;
         OP_BLT:  w_br_taken = w_br_lt;
         OP_BGE:  w_br_taken = !w_br_lt;
         OP_BLTU: w_br_taken = w_br_ltu;
         OP_BGEU: w_br_taken = !w_br_ltu;
         default: w_br_taken = 1'b0;
      endcase
   end

   // Jumps override alu_ctrl entirely: link address as result, always taken.
   assign w_jump     = bus.is_jal || bus.is_jalr;
   assign w_taken    = w_jump || w_br_taken;
   assign w_pc4      = bus.pc + XLEN'(4);
   assign w_jalr_sum = bus.rs1_data + bus.imm;
   assign w_target   = bus.is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : (bus.pc + bus.imm);
   assign w_result   = w_jump ? w_pc4 : w_alu;

   // Handshake
   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

   // EX/MEM register: flush beats accept beats drain; a stall holds everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid      <= 1'b0;
         r_out_result     <= '0;
         r_out_store_data <= '0;
         r_out_rd         <= '0;
         r_out_reg_write  <= 1'b0;
         r_out_mem_read   <= 1'b0;
         r_out_mem_write  <= 1'b0;
         r_out_funct3     <= '0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid      <= 1'b1;
         r_out_result     <= w_result;
         r_out_store_data <= bus.rs2_data;
         r_out_rd         <= bus.rd_addr;
         r_out_reg_write  <= bus.reg_write;
         r_out_mem_read   <= bus.mem_read;
         r_out_mem_write  <= bus.mem_write;
         r_out_funct3     <= bus.funct3;
      end else if (w_in_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Redirect pulses on acceptance of a taken control transfer, independent
   // of any later MEM stall; the target register keeps its last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_redirect_valid  <= 1'b0;
         r_redirect_target <= RESET_PC_TGT;
      end else begin
         r_redirect_valid <= w_accept && w_taken;
         if (w_accept && w_taken)
            r_redirect_target <= w_target;
      end
   end

   assign bus.in_ready        = w_in_ready;
   assign bus.out_valid       = r_out_valid;
   assign bus.out_result      = r_out_result;
   assign bus.out_store_data  = r_out_store_data;
   assign bus.out_rd          = r_out_rd;
   assign bus.out_reg_write   = r_out_reg_write;
   assign bus.out_mem_read    = r_out_mem_read;
   assign bus.out_mem_write   = r_out_mem_write;
   assign bus.out_funct3      = r_out_funct3;
   assign bus.redirect_valid  = r_redirect_valid;
   assign bus.redirect_target = r_redirect_target;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized
// run against a behavioural model of the execute stage.
module tb_ex_stage;
   localparam logic [31:0] RST_TGT = 32'hDEAD_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ex_stage_if #(.XLEN(32)) bus ();

   ex_stage #(.XLEN(32), .RESET_PC_TGT(RST_TGT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference model: what one instruction produces, from the ISA rules.
   function automatic void ref_exec(
      input  logic [3:0]  c,
      input  logic [31:0] a, r2, im, p,
      input  bit          bs, jal, jalr,
      output logic [31:0] res,
      output bit          tk,
      output logic [31:0] tgt);
      logic [31:0] b;
      int          sa;
      longint      sa_val;
      b   = bs ? im : r2;
      sa  = int'(b % 32);
      res = 32'h0;
      tk  = 1'b0;
      tgt = p + im;
      if (jal || jalr) begin
         res = p + 32'd4;
         tk  = 1'b1;
         if (jalr) tgt = (a + im) & 32'hFFFF_FFFE;
         return;
      end
      case (c)
         4'd0:  res = a + b;
         4'd1:  res = a - b;
         4'd2:  res = 32'((64'(a) * (64'd1 << sa)));
         4'd3:  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
         4'd4:  res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
         4'd5:  res = a ^ b;
         4'd6:  res = 32'(64'(a) / (64'd1 << sa));
         4'd7:  begin
                   sa_val = longint'(int'(a));
                   // floor division by 2^sa is an arithmetic right shift
                   if (sa_val < 0) res = 32'(-((-sa_val + (longint'(1) << sa) - 1) / (longint'(1) << sa)));
                   else            res = 32'(sa_val / (longint'(1) << sa));
                end
         4'd8:  res = a | b;
         4'd9:  res = a & b;
         4'd10: tk = (a == r2);
         4'd11: tk = (a != r2);
         4'd12: tk = (int'(a) < int'(r2));
         4'd13: tk = !(int'(a) < int'(r2));
         4'd14: tk = (longint'(a) < longint'(r2));
         default: tk = !(longint'(a) < longint'(r2));
      endcase
   endfunction

   task automatic drive_idle();
      bus.in_valid = 0; bus.alu_ctrl = 0; bus.rs1_data = 0; bus.rs2_data = 0;
      bus.imm = 0; bus.pc = 0; bus.b_sel = 0; bus.is_jal = 0; bus.is_jalr = 0;
      bus.rd_addr = 0; bus.reg_write = 0; bus.mem_read = 0; bus.mem_write = 0;
      bus.funct3 = 0; bus.flush = 0; bus.out_ready = 1;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [31:0] a, r2, im, p,
                            input bit bs, jal, jalr);
      bus.alu_ctrl = c; bus.rs1_data = a; bus.rs2_data = r2; bus.imm = im;
      bus.pc = p; bus.b_sel = bs; bus.is_jal = jal; bus.is_jalr = jalr;
   endtask

   // Present one instruction for exactly one edge; returns at edge+1.
   task automatic issue();
      bus.in_valid = 1;
      @(posedge clk); #1;
      bus.in_valid = 0;
   endtask

   task automatic test_reset();
      drive_idle();
      rst_n = 0;
      #12;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      n_chk++; if (bus.out_result !== 32'h0) begin n_err++; $display("FAIL reset_out_result got=%h exp=0", bus.out_result); end
      n_chk++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect_valid got=%b exp=0", bus.redirect_valid); end
      n_chk++; if (bus.redirect_target !== RST_TGT) begin n_err++; $display("FAIL reset_redirect_target got=%h exp=%h", bus.redirect_target, RST_TGT); end
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      #1 rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      set_instr(4'd0, 32'd5, 32'd7, 32'd99, 32'h40, 0, 0, 0);
      bus.rd_addr = 5'd3; bus.reg_write = 1; bus.funct3 = 3'd2; bus.mem_write = 1;
      issue();
      n_chk++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got=%b exp=1", bus.out_valid); end
      n_chk++; if (bus.out_result !== 32'd12) begin n_err++; $display("FAIL add_result got=%h exp=%h", bus.out_result, 32'd12); end
      n_chk++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL add_redirect got=%b exp=0", bus.redirect_valid); end
      n_chk++; if ({bus.out_rd, bus.out_reg_write, bus.out_mem_write, bus.out_funct3, bus.out_store_data} !== {5'd3, 1'b1, 1'b1, 3'd2, 32'd7})
         begin n_err++; $display("FAIL add_ctrl_fwd got=%h exp=%h", {bus.out_rd, bus.out_reg_write, bus.out_mem_write, bus.out_funct3, bus.out_store_data}, {5'd3, 1'b1, 1'b1, 3'd2, 32'd7}); end
      drive_idle();
   endtask

   task automatic test_shift_sub();
      logic [3:0]  ops [3] = '{4'd7, 4'd6, 4'd1};
      logic [31:0] exp [3] = '{32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         if (i < 2) set_instr(ops[i], 32'h8000_0000, 32'd0, 32'd4, 32'h0, 1, 0, 0);
         else       set_instr(ops[i], 32'd0, 32'd1, 32'd4, 32'h0, 0, 0, 0);
         issue();
         n_chk++; if (bus.out_result !== exp[i]) begin n_err++; $display("FAIL shift_sub_%0d got=%h exp=%h", i, bus.out_result, exp[i]); end
      end
      drive_idle();
   endtask

   task automatic test_branch();
      set_instr(4'd12, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 0, 0, 0);
      issue();
      n_chk++; if ({bus.redirect_valid, bus.redirect_target, bus.out_result} !== {1'b1, 32'h120, 32'h0})
         begin n_err++; $display("FAIL blt_taken got=%h exp=%h", {bus.redirect_valid, bus.redirect_target, bus.out_result}, {1'b1, 32'h120, 32'h0}); end
      @(posedge clk); #1;
      n_chk++; if (bus.redirect_valid !== 1'b0) begin n_err++; $display("FAIL blt_pulse_width got=%b exp=0", bus.redirect_valid); end
      set_instr(4'd14, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 0, 0, 0);
      issue();
      n_chk++; if ({bus.out_valid, bus.redirect_valid, bus.out_result, bus.redirect_target} !== {1'b1, 1'b0, 32'h0, 32'h120})
         begin n_err++; $display("FAIL bltu_not_taken got=%h exp=%h", {bus.out_valid, bus.redirect_valid, bus.out_result, bus.redirect_target}, {1'b1, 1'b0, 32'h0, 32'h120}); end
      drive_idle();
   endtask

   task automatic test_jalr();
      set_instr(4'd9, 32'h1003, 32'h0, 32'd4, 32'h200, 1, 0, 1);
      issue();
      n_chk++; if ({bus.out_result, bus.redirect_valid, bus.redirect_target} !== {32'h204, 1'b1, 32'h1006})
         begin n_err++; $display("FAIL jalr got=%h exp=%h", {bus.out_result, bus.redirect_valid, bus.redirect_target}, {32'h204, 1'b1, 32'h1006}); end
      @(posedge clk); #1;
      n_chk++; if ({bus.redirect_valid, bus.redirect_target} !== {1'b0, 32'h1006})
         begin n_err++; $display("FAIL jalr_pulse got=%h exp=%h", {bus.redirect_valid, bus.redirect_target}, {1'b0, 32'h1006}); end
      drive_idle();
   endtask

   task automatic test_stall();
      bus.out_ready = 0;
      set_instr(4'd0, 32'd1, 32'd2, 32'd0, 32'h0, 0, 0, 0);
      issue();
      set_instr(4'd0, 32'd10, 32'd20, 32'd0, 32'h0, 0, 0, 0);
      bus.in_valid = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if ({bus.in_ready, bus.out_valid, bus.out_result} !== {1'b0, 1'b1, 32'd3})
            begin n_err++; $display("FAIL stall_hold_%0d got=%h exp=%h", i, {bus.in_ready, bus.out_valid, bus.out_result}, {1'b0, 1'b1, 32'd3}); end
         @(posedge clk); #1;
      end
      bus.out_ready = 1;
      #1;
      n_chk++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      bus.in_valid = 0;
      n_chk++; if ({bus.out_valid, bus.out_result} !== {1'b1, 32'd30})
         begin n_err++; $display("FAIL stall_next_accept got=%h exp=%h", {bus.out_valid, bus.out_result}, {1'b1, 32'd30}); end
      @(posedge clk); #1;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stall_no_dup got=%b exp=0", bus.out_valid); end
      drive_idle();
   endtask

   task automatic test_flush();
      bus.out_ready = 0;
      set_instr(4'd0, 32'd4, 32'd4, 32'd0, 32'h0, 0, 0, 0);
      issue();
      set_instr(4'd0, 32'd0, 32'd0, 32'h40, 32'h300, 0, 1, 0);
      bus.in_valid = 1; bus.flush = 1;
      @(posedge clk); #1;
      n_chk++; if ({bus.out_valid, bus.redirect_valid} !== 2'b00)
         begin n_err++; $display("FAIL flush got=%b exp=00", {bus.out_valid, bus.redirect_valid}); end
      drive_idle();
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      bus.out_ready = 0;
      set_instr(4'd0, 32'd0, 32'd0, 32'h80, 32'h400, 0, 1, 0);
      bus.rd_addr = 5'd9; bus.reg_write = 1;
      issue();
      drive_idle();
      bus.out_ready = 0;
      #2 rst_n = 0;
      #1;
      n_chk++; if ({bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.redirect_valid, bus.redirect_target} !== {1'b0, 32'h0, 5'd0, 1'b0, 1'b0, RST_TGT})
         begin n_err++; $display("FAIL async_reset got=%h exp=%h", {bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write, bus.redirect_valid, bus.redirect_target}, {1'b0, 32'h0, 5'd0, 1'b0, 1'b0, RST_TGT}); end
      #1 rst_n = 1;
      bus.out_ready = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit          ev, erv, acc, rdy, tk;
      logic [31:0] eres, esd, etgt, res, tgt;
      logic [4:0]  erd;
      logic [2:0]  ef3;
      logic [2:0]  ectl;
      int          kind;
      ev = 0; erv = 0; etgt = RST_TGT; eres = 0; esd = 0; erd = 0; ef3 = 0; ectl = 0;
      rst_n = 0; #1 rst_n = 1;
      @(posedge clk); #1;
      for (int n = 0; n < 300; n++) begin
         kind = $urandom_range(0, 19);
         set_instr(4'($urandom_range(0, 15)),
                   (kind < 6) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom,
                   (kind < 6) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom,
                   $urandom, $urandom, 1'($urandom), kind == 18, kind == 19);
         bus.rd_addr = 5'($urandom); bus.reg_write = 1'($urandom);
         bus.mem_read = 1'($urandom); bus.mem_write = 1'($urandom);
         bus.funct3 = 3'($urandom);
         bus.in_valid  = ($urandom_range(0, 9) < 7);
         bus.out_ready = ($urandom_range(0, 9) < 7);
         bus.flush     = ($urandom_range(0, 9) == 0);
         #1;
         rdy = !ev || bus.out_ready;
         n_chk++; if (bus.in_ready !== rdy) begin n_err++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", n, bus.in_ready, rdy); end
         ref_exec(bus.alu_ctrl, bus.rs1_data, bus.rs2_data, bus.imm, bus.pc,
                  bus.b_sel, bus.is_jal, bus.is_jalr, res, tk, tgt);
         acc = bus.in_valid && rdy && !bus.flush;
         if (bus.flush) ev = 0;
         else if (acc) begin
            ev = 1; eres = res; esd = bus.rs2_data; erd = bus.rd_addr; ef3 = bus.funct3;
            ectl = {bus.reg_write, bus.mem_read, bus.mem_write};
         end else if (rdy) ev = 0;
         erv = acc && tk;
         if (erv) etgt = tgt;
         @(posedge clk); #1;
         n_chk++; if (bus.out_valid !== ev) begin n_err++; $display("FAIL rand_valid[%0d] got=%b exp=%b", n, bus.out_valid, ev); end
         if (ev) begin
            n_chk++;
            if ({bus.out_result, bus.out_store_data, bus.out_rd, bus.out_funct3, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write} !== {eres, esd, erd, ef3, ectl})
               begin n_err++; $display("FAIL rand_data[%0d] got=%h exp=%h", n, {bus.out_result, bus.out_store_data, bus.out_rd, bus.out_funct3, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}, {eres, esd, erd, ef3, ectl}); end
         end
         n_chk++; if ({bus.redirect_valid, bus.redirect_target} !== {erv, etgt})
            begin n_err++; $display("FAIL rand_redirect[%0d] got=%h exp=%h", n, {bus.redirect_valid, bus.redirect_target}, {erv, etgt}); end
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_add();
      test_shift_sub();
      test_branch();
      test_jalr();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
